// File: rtl/mux2a1_cuatrobits_tx.sv
`default_nettype none
// ============================================================================
// Module   : mux2a1_cuatrobits_tx
// Purpose  : Two-lane 4-bit buffered 2:1 interleaver; emits lane0, lane1,
//            lane0, ... on one registered output stream.
// Revision : 1.0 - initial release
// ============================================================================
module mux2a1_cuatrobits_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       valid_in0,
    input  logic [3:0] data_in0,
    output logic       ready_in0,
    input  logic       valid_in1,
    input  logic [3:0] data_in1,
    output logic       ready_in1,
    output logic       valid_out,
    output logic [3:0] data_out,
    output logic [7:0] words_sent
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    logic [1:0]      w_valid_in;
    logic [1:0][3:0] w_data_in;
    logic [1:0]      w_ready;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic [1:0][3:0] w_head;
    logic            w_pop_sel;
    logic [3:0]      w_head_sel;

    logic            r_sel;
    logic            r_valid_out;
    logic [3:0]      r_data_out;
    logic [7:0]      r_words_sent;

    assign w_valid_in = {valid_in1, valid_in0};
    assign w_data_in  = {data_in1, data_in0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [3:0]         r_mem [FIFO_DEPTH];
            logic [c_PTR_W-1:0] r_wr_ptr;
            logic [c_PTR_W-1:0] r_rd_ptr;
            logic [c_CNT_W-1:0] r_count;

            // Ready looks only at registered occupancy, never at a same-cycle pop.
            assign w_ready[gi] = ~reset & (r_count < c_FULL);
            assign w_push[gi]  = w_valid_in[gi] & w_ready[gi];
            assign w_pop[gi]   = (r_sel == 1'(gi)) & (r_count != '0);
            assign w_head[gi]  = r_mem[r_rd_ptr];

            always_ff @(posedge clk_8f) begin
                if (w_push[gi]) begin
                    r_mem[r_wr_ptr] <= w_data_in[gi];
                end
            end

            always_ff @(posedge clk_8f) begin
                if (reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // The selector never skips an empty lane; that keeps the k-th words paired.
    assign w_pop_sel  = w_pop[r_sel];
    assign w_head_sel = w_head[r_sel];

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_sel        <= 1'b0;
            r_valid_out  <= 1'b0;
            r_data_out   <= 4'h0;
            r_words_sent <= 8'd0;
        end else if (w_pop_sel) begin
            r_sel        <= ~r_sel;
            r_valid_out  <= 1'b1;
            r_data_out   <= w_head_sel;
            r_words_sent <= r_words_sent + 8'd1;
        end else begin
            r_valid_out  <= 1'b0;
        end
    end

    assign ready_in0  = w_ready[0];
    assign ready_in1  = w_ready[1];
    assign valid_out  = r_valid_out;
    assign data_out   = r_data_out;
    assign words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_mux2a1_cuatrobits_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2a1_cuatrobits_tx
// Purpose  : Self-checking bench: queue-based reference model plus a
//            receiver-side 1-to-2 demux scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2a1_cuatrobits_tx;

    localparam int c_DEPTH = 4;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic       valid_in0, valid_in1;
    logic [3:0] data_in0, data_in1;
    logic       ready_in0, ready_in1;
    logic       valid_out;
    logic [3:0] data_out;
    logic [7:0] words_sent;

    mux2a1_cuatrobits_tx #(.FIFO_DEPTH(c_DEPTH)) u_dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .valid_in0  (valid_in0),
        .data_in0   (data_in0),
        .ready_in0  (ready_in0),
        .valid_in1  (valid_in1),
        .data_in1   (data_in1),
        .ready_in1  (ready_in1),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .words_sent (words_sent)
    );

    always #5 clk_8f = ~clk_8f;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each lane is a bounded queue, the output alternates lanes.
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    bit         m_sel;
    bit         m_valid;
    logic [3:0] m_data;
    int         m_words;

    // Receiver-side demux scoreboard: every accepted word, per lane, in order.
    logic [3:0] sb0[$];
    logic [3:0] sb1[$];
    bit         rx_lane;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        bit         a0, a1, rst;
        logic [3:0] d0, d1, w;
        @(negedge clk_8f);
        rst = reset;
        check("ready0", ready_in0, (!rst && q0.size() < c_DEPTH));
        check("ready1", ready_in1, (!rst && q1.size() < c_DEPTH));
        a0 = !rst && valid_in0 && (q0.size() < c_DEPTH);
        a1 = !rst && valid_in1 && (q1.size() < c_DEPTH);
        d0 = data_in0;
        d1 = data_in1;
        @(posedge clk_8f);
        #1;
        if (rst) begin
            q0.delete(); q1.delete(); sb0.delete(); sb1.delete();
            m_sel = 1'b0; m_valid = 1'b0; m_data = 4'h0; m_words = 0; rx_lane = 1'b0;
        end else begin
            if (!m_sel && q0.size() > 0) begin
                m_data = q0.pop_front(); m_valid = 1'b1; m_words++; m_sel = 1'b1;
            end else if (m_sel && q1.size() > 0) begin
                m_data = q1.pop_front(); m_valid = 1'b1; m_words++; m_sel = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
            if (valid_out === 1'b1) begin
                if ((rx_lane ? sb1.size() : sb0.size()) == 0) begin
                    check("demux_empty", 1, 0);
                end else begin
                    w = rx_lane ? sb1.pop_front() : sb0.pop_front();
                    check(rx_lane ? "demux_lane1" : "demux_lane0", data_out, w);
                end
                rx_lane = ~rx_lane;
            end
            if (a0) begin q0.push_back(d0); sb0.push_back(d0); end
            if (a1) begin q1.push_back(d1); sb1.push_back(d1); end
        end
        check("valid_out", valid_out, m_valid);
        check("data_out", data_out, m_data);
        check("words_sent", words_sent, m_words % 256);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("ready_after_rst", {ready_in1, ready_in0}, 2'b11);
    endtask

    initial begin
        reset = 1'b1;
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        data_in0 = 4'h0; data_in1 = 4'h0;
        step();
        step();
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 4'h0);
        check("rst_words", words_sent, 0);

        // Simultaneous push on both lanes.
        do_reset();
        valid_in0 = 1'b1; data_in0 = 4'hA; valid_in1 = 1'b1; data_in1 = 4'h5;
        step();
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        step();
        check("pair_first", {valid_out, data_out}, {1'b1, 4'hA});
        step();
        check("pair_second", {valid_out, data_out}, {1'b1, 4'h5});
        check("pair_words", words_sent, 2);

        // Lane 1 alone must wait for lane 0.
        do_reset();
        valid_in1 = 1'b1; data_in1 = 4'h3;
        step();
        valid_in1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait_idle", {valid_out, data_out}, {1'b0, 4'h0});
        end
        valid_in0 = 1'b1; data_in0 = 4'h7;
        step();
        valid_in0 = 1'b0;
        step();
        check("wait_first", {valid_out, data_out}, {1'b1, 4'h7});
        step();
        check("wait_second", {valid_out, data_out}, {1'b1, 4'h3});

        // Lane 0 backpressure with lane 1 starved, then release.
        do_reset();
        valid_in0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in0 = 4'(i + 1);
            step();
        end
        check("bp_ready0", ready_in0, 0);
        check("bp_words", words_sent, 1);
        valid_in0 = 1'b0;
        valid_in1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in1 = 4'(8 + i);
            step();
        end
        valid_in1 = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("bp_total_words", words_sent, 10);

        // Sustained throughput and counter wrap.
        do_reset();
        valid_in0 = 1'b1; valid_in1 = 1'b1;
        for (int i = 0; i <= 300; i++) begin
            data_in0 = 4'(i);
            data_in1 = ~4'(i);
            step();
            if (i > 0) check("stream_valid", valid_out, 1);
            if (i == 256) check("stream_wrap", words_sent, 0);
        end
        check("stream_words", words_sent, 44);

        // Mid-stream reset discards buffered words.
        do_reset();
        valid_in0 = 1'b1; data_in0 = 4'h1; valid_in1 = 1'b1; data_in1 = 4'h2;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_occ", q0.size() * 16 + q1.size(), 3 * 16 + 3);
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        reset = 1'b1;
        step();
        check("mid_rst_out", {valid_out, data_out, words_sent}, 13'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {ready_in1, ready_in0}, 2'b11);
        valid_in0 = 1'b1; data_in0 = 4'hE; valid_in1 = 1'b1; data_in1 = 4'hD;
        step();
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        step();
        check("post_rst_first", {valid_out, data_out}, {1'b1, 4'hE});
        step();
        check("post_rst_second", {valid_out, data_out}, {1'b1, 4'hD});
        for (int i = 0; i < 4; i++) step();

        // Random stalls on both lanes.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            valid_in0 = ($urandom_range(0, 3) != 0);
            valid_in1 = ($urandom_range(0, 2) == 0);
            data_in0 = 4'($urandom);
            data_in1 = 4'($urandom);
            step();
        end
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux2a1_cuatrobits_tx.md
MUX2A1_CUATROBITS_TX -- requirements
Module: mux2a1_cuatrobits_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, per-lane buffer depth in 4-bit words; legal values are powers of 2 from 2 to 16.
REQ-002 clk_8f  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk_8f.
REQ-004 valid_in0  input  1  lane-0 word present.
REQ-005 data_in0  input  4  lane-0 word.
REQ-006 ready_in0  output  1  lane-0 buffer can accept a word this cycle.
REQ-007 valid_in1  input  1  lane-1 word present.
REQ-008 data_in1  input  4  lane-1 word.
REQ-009 ready_in1  output  1  lane-1 buffer can accept a word this cycle.
REQ-010 valid_out  output  1  data_out carries a word this cycle, registered.
REQ-011 data_out  output  4  interleaved serial word stream, registered.
REQ-012 words_sent  output  8  count of words emitted on data_out, registered.

Function
REQ-013 Each lane SHALL have an independent FIFO of FIFO_DEPTH 4-bit words with read pointer, write pointer and occupancy count.
REQ-014 ready_inN SHALL be 1 iff reset is 0 and lane N occupancy < FIFO_DEPTH; it is computed from registered occupancy only and does not depend on a same-cycle pop.
REQ-015 A lane-N push SHALL occur on an edge where valid_inN=1 and ready_inN=1; valid_inN=1 with ready_inN=0 SHALL leave the FIFO unchanged, so no data is written and none is lost.
REQ-016 A 1-bit lane selector sel SHALL choose the lane to pop; output order SHALL strictly alternate lane0, lane1, lane0, ... and start with lane 0 after reset.
REQ-017 On each edge with occupancy[sel]>0, the block SHALL pop the head of lane sel, set data_out to that word, set valid_out to 1, and toggle sel.
REQ-018 On each edge with occupancy[sel]=0, the block SHALL set valid_out to 0, hold data_out at its previous value, and hold sel; it SHALL NOT skip to the other lane even if that lane is non-empty.
REQ-019 A push and a pop on the same lane in the same edge SHALL leave that lane's occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 Latency: a word pushed at edge N into an empty, currently selected lane SHALL appear on data_out with valid_out=1 after edge N+1; there is no combinational bypass.
REQ-021 words_sent SHALL increment by 1 on every edge where valid_out is set to 1, and SHALL wrap from 255 to 0.
REQ-022 Sustained throughput with both lanes continuously fed SHALL be one word per clk_8f cycle, i.e. each lane drains at half rate.
REQ-023 Pairing invariant: the k-th lane-0 word SHALL always be emitted immediately before the k-th lane-1 word, whatever the stall pattern.

Reset
REQ-024 While reset=1 at an edge, the block SHALL set sel=0, all pointers and occupancies=0, valid_out=0, data_out=4'h0 and words_sent=0; pushes and pops are ignored.
REQ-025 ready_in0 and ready_in1 SHALL be 0 while reset=1 and SHALL be 1 in the first cycle after reset deasserts.
REQ-026 Reset asserted mid-stream SHALL discard all buffered words; the first word emitted after reset SHALL be lane-0 data pushed after reset.

Verification
REQ-027 After reset, push lane0=4'hA and lane1=4'h5 at the same edge N -> data_out=4'hA with valid_out=1 after N+1, then data_out=4'h5 with valid_out=1 after N+2, and words_sent=2.
REQ-028 Push lane1=4'h3 only, no lane-0 data for 5 cycles -> valid_out=0 and data_out=4'h0 throughout; then push lane0=4'h7 -> output 4'h7 then 4'h3 on consecutive cycles.
REQ-029 Hold valid_in0=1 with no lane-1 data, FIFO_DEPTH=4 -> one lane-0 word emitted, then 4 more accepted and ready_in0=0; extra beats are not consumed, and when lane 1 is fed all 5 lane-0 words emerge in order.
REQ-030 Both lanes fed every cycle for 300 cycles with incrementing values -> valid_out=1 every cycle after the first, strict alternation, words_sent wraps 255->0 and then reads 44 after 300 words.
REQ-031 Assert reset for 1 cycle with 3 words buffered per lane -> outputs zero next cycle, ready_inN=1 after deassert, and no pre-reset word ever appears.
REQ-032 Random valid_inN stalls over 10k cycles -> output stream equals the reference interleave of both lane input sequences, as checked by the receiver-side 1-to-2 demux scoreboard.
